n64_pi_bus_ctrl: RTL
====================

N64_PI_BUS_CTRL -- requirements
Module: n64_pi_bus_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth for N64_AD_IN, N64_ALE_H, N64_ALE_L and N64_READ_N (minimum 2).
REQ-002 SHALL have parameter ROM_BASE, default 32'h1000_0000: first serviced bus address.
REQ-003 SHALL have parameter ROM_LIMIT, default 32'h1FC0_0000: first address above the serviced window.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port N64_AD_IN, input, 16 bits: cartridge AD bus, sampled value.
REQ-007 SHALL have port N64_AD_OUT, output, 16 bits: data to drive onto the AD bus.
REQ-008 SHALL have port N64_AD_OE, output, 1 bit: AD bus output enable.
REQ-009 SHALL have ports N64_ALE_H, N64_ALE_L and N64_READ_N, inputs, 1 bit each: raw PI bus strobes.
REQ-010 SHALL have port rom_req, output, 1 bit: fetch request to the ROM store.
REQ-011 SHALL have port rom_addr, output, 32 bits: fetch address, halfword aligned.
REQ-012 SHALL have port rom_ack, input, 1 bit: single-cycle fetch completion.
REQ-013 SHALL have port rom_data, input, 16 bits: fetch data, valid while rom_ack is 1.
REQ-014 SHALL have port bus_addr, output, 32 bits: current latched or incremented bus address.
REQ-015 SHALL have port underrun, output, 1 bit: one-cycle pulse when a read strobe arrives before its data is ready.

Function
REQ-016 SHALL pass all four bus inputs through an identical SYNC_STAGES flop chain, so AD stays aligned with the strobes; edges are detected on the synchronized signals only.
REQ-017 SHALL implement states IDLE, ADDR_HI, FETCH, READY, DRIVE and MISS.
REQ-018 SHALL make IDLE->ADDR_HI on a synced ALE_H falling edge, capturing synced AD into bus_addr[31:16].
REQ-019 SHALL make ADDR_HI->FETCH on a synced ALE_L falling edge, capturing synced AD into bus_addr[15:0] with bit 0 forced to 0.
REQ-020 SHALL go ADDR_HI->MISS instead when the assembled address is < ROM_BASE or >= ROM_LIMIT; in MISS, rom_req and N64_AD_OE stay 0 and READ_N is ignored.
REQ-021 SHALL assert rom_req on the clock edge that enters FETCH, with rom_addr = bus_addr; both SHALL be held stable until the rom_ack cycle.
REQ-022 SHALL, in the rom_ack cycle, register rom_data into a data holding register, deassert rom_req on that edge, and move to READY.
REQ-023 SHALL make READY->DRIVE on a synced READ_N falling edge, with N64_AD_OE = 1 and N64_AD_OUT = held data from the next edge.
REQ-024 SHALL make DRIVE->FETCH on a synced READ_N rising edge, with N64_AD_OE = 0 and bus_addr += 2 (full 32-bit, 0xFFFF carries into the upper half, 32'hFFFF_FFFE wraps to 0).
REQ-025 SHALL, on a READ_N falling edge in FETCH, pulse underrun for one cycle and enter DRIVE on acknowledgement, keeping N64_AD_OE = 0 until rom_ack.
REQ-026 SHALL give a synced ALE_H rising edge priority over all other events in every state: go to IDLE, drop rom_req (abort), N64_AD_OE = 0.
REQ-027 SHALL ignore rom_ack outside FETCH.
REQ-028 SHALL give a latency of SYNC_STAGES+1 clk edges from ALE_L first sampled low to rom_req = 1.

Reset
REQ-029 SHALL, with resetn = 0 at a clk edge, set state = IDLE, rom_req = 0, rom_addr = 0, bus_addr = 0, N64_AD_OUT = 0, N64_AD_OE = 0, underrun = 0, and all synchronizer flops to 1; this holds even mid-transfer.

Verification
REQ-030 SHALL check this read: ALE_H falls with AD = 16'h1000, ALE_L falls with AD = 16'h0040 -> rom_req with rom_addr = 32'h1000_0040 after 3 clks; ack with rom_data = 16'h8037, then READ_N low -> N64_AD_OE = 1 and N64_AD_OUT = 16'h8037.
REQ-031 SHALL check a burst: 4 READ_N pulses from 32'h1000_FFFC -> rom_addr sequence 1000_FFFC, 1000_FFFE, 1001_0000, 1001_0002.
REQ-032 SHALL check a miss: address 32'h0500_0000 or 32'h1FC0_0000 -> no rom_req and N64_AD_OE stays 0 across READ_N pulses.
REQ-033 SHALL check an underrun: rom_ack delayed 10 clks while READ_N falls -> one underrun pulse, N64_AD_OE = 0 until the ack, then 1 with the acked data.
REQ-034 SHALL check an abort: ALE_H rises during FETCH and during DRIVE -> rom_req = 0 and N64_AD_OE = 0 the next clk, state = IDLE, and a new address is accepted.
REQ-035 SHALL check reset: resetn low for 1 clk in DRIVE -> all outputs take the REQ-029 values and the next transaction completes normally.

Source files
------------

// File: rtl/n64_pi_bus_ctrl.sv
// N64 cartridge PI bus slave: synchronises the raw AD/strobe lines, latches the
// bus address, prefetches halfwords from a ROM store and drives them on reads.
module n64_pi_bus_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] ROM_BASE    = 32'h1000_0000,
  parameter logic [31:0] ROM_LIMIT   = 32'h1FC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] N64_AD_IN,
  output logic [15:0] N64_AD_OUT,
  output logic        N64_AD_OE,
  input  logic        N64_ALE_H,
  input  logic        N64_ALE_L,
  input  logic        N64_READ_N,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic [31:0] bus_addr,
  output logic        underrun
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = DW + 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    FETCH   = 3'd2,
    READY   = 3'd3,
    DRIVE   = 3'd4,
    MISS    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sync_q [SYNC_STAGES];
  logic [2:0]      strb_prev_q;
  logic            rom_req_q, rom_req_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   ad_out_q, ad_out_d;
  logic            ad_oe_q, ad_oe_d;
  logic            underrun_q, underrun_d;
  logic            pend_q, pend_d;

  logic [DW-1:0]   ad_s;
  logic            ale_h_s, ale_l_s, read_n_s;
  logic            ale_h_rise, ale_h_fall, ale_l_fall, read_fall, read_rise;
  logic [AW-1:0]   fetch_addr;
  logic [AW-1:0]   next_addr;
  logic            addr_ok;

  // AD and strobes share one chain so the captured address matches its strobe
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '1;
      end
      strb_prev_q <= '1;
    end else begin
      sync_q[0] <= {N64_AD_IN, N64_ALE_H, N64_ALE_L, N64_READ_N};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      strb_prev_q <= {ale_h_s, ale_l_s, read_n_s};
    end
  end

  assign ad_s     = sync_q[SYNC_STAGES-1][SW-1:3];
  assign ale_h_s  = sync_q[SYNC_STAGES-1][2];
  assign ale_l_s  = sync_q[SYNC_STAGES-1][1];
  assign read_n_s = sync_q[SYNC_STAGES-1][0];

  assign ale_h_rise = ~strb_prev_q[2] &  ale_h_s;
  assign ale_h_fall =  strb_prev_q[2] & ~ale_h_s;
  assign ale_l_fall =  strb_prev_q[1] & ~ale_l_s;
  assign read_fall  =  strb_prev_q[0] & ~read_n_s;
  assign read_rise  = ~strb_prev_q[0] &  read_n_s;

  assign fetch_addr = {bus_addr_q[AW-1:DW], ad_s[DW-1:1], 1'b0};
  assign addr_ok    = (fetch_addr >= ROM_BASE) && (fetch_addr < ROM_LIMIT);
  assign next_addr  = bus_addr_q + AW'(2);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
      bus_addr_q <= '0;
      data_q     <= '0;
      ad_out_q   <= '0;
      ad_oe_q    <= 1'b0;
      underrun_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      bus_addr_q <= bus_addr_d;
      data_q     <= data_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      underrun_q <= underrun_d;
      pend_q     <= pend_d;
    end
  end

  // pend_q remembers a read strobe that arrived while the fetch was still out
  always_comb begin
    state_d    = state_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    bus_addr_d = bus_addr_q;
    data_d     = data_q;
    ad_out_d   = ad_out_q;
    ad_oe_d    = ad_oe_q;
    underrun_d = 1'b0;
    pend_d     = pend_q;

    if (ale_h_rise) begin
      state_d   = IDLE;
      rom_req_d = 1'b0;
      ad_oe_d   = 1'b0;
      pend_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ale_h_fall) begin
            bus_addr_d[AW-1:DW] = ad_s;
            state_d             = ADDR_HI;
          end
        end
        ADDR_HI: begin
          if (ale_l_fall) begin
            bus_addr_d = fetch_addr;
            if (addr_ok) begin
              state_d    = FETCH;
              rom_req_d  = 1'b1;
              rom_addr_d = fetch_addr;
            end else begin
              state_d = MISS;
            end
          end
        end
        FETCH: begin
          if (rom_ack) begin
            data_d    = rom_data;
            rom_req_d = 1'b0;
            pend_d    = 1'b0;
            if (pend_q || read_fall) begin
              state_d  = DRIVE;
              ad_oe_d  = 1'b1;
              ad_out_d = rom_data;
            end else begin
              state_d = READY;
            end
          end else if (read_fall) begin
            underrun_d = 1'b1;
            pend_d     = 1'b1;
          end else if (read_rise) begin
            pend_d = 1'b0;
          end
        end
        READY: begin
          if (read_fall) begin
            state_d  = DRIVE;
            ad_oe_d  = 1'b1;
            ad_out_d = data_q;
          end
        end
        DRIVE: begin
          if (read_rise) begin
            state_d    = FETCH;
            ad_oe_d    = 1'b0;
            bus_addr_d = next_addr;
            rom_req_d  = 1'b1;
            rom_addr_d = next_addr;
          end
        end
        MISS: begin
          state_d = MISS;
        end
        default: begin
          state_d   = IDLE;
          rom_req_d = 1'b0;
          ad_oe_d   = 1'b0;
          pend_d    = 1'b0;
        end
      endcase
    end
  end

  assign N64_AD_OUT = ad_out_q;
  assign N64_AD_OE  = ad_oe_q;
  assign rom_req    = rom_req_q;
  assign rom_addr   = rom_addr_q;
  assign bus_addr   = bus_addr_q;
  assign underrun   = underrun_q;

endmodule
